// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces an active-low pushbutton with press, release and long-press pulses
module btn_debounce #(
  parameter int DB_CNT = 50000,
  parameter int LONG_CNT = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnIn,
  output logic btnOut,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [23:0] DB_LAST = 24'(DB_CNT - 1);
  localparam logic [23:0] LONG_MAX = 24'(LONG_CNT);
  state_t state, state_n;
  logic sync1, s;
  logic [23:0] db_cnt, db_cnt_n, hold_cnt, hold_cnt_n;
  logic btn_n, press_n, release_n, long_n;
  logic accept, held;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      s <= 1'b1;
      state <= RELEASED;
      db_cnt <= '0;
      hold_cnt <= '0;
      btnOut <= 1'b1;
      pressPulse <= 1'b0;
      releasePulse <= 1'b0;
      longPress <= 1'b0;
    end else begin
      sync1 <= btnIn;
      s <= sync1;
      state <= state_n;
      db_cnt <= db_cnt_n;
      hold_cnt <= hold_cnt_n;
      btnOut <= btn_n;
      pressPulse <= press_n;
      releasePulse <= release_n;
      longPress <= long_n;
    end
  end
  always_comb begin
    accept = db_cnt == DB_LAST;
    held = state == PRESSED || state == RELEASE_WAIT;
    state_n = state;
    db_cnt_n = '0;
    btn_n = btnOut;
    press_n = 1'b0;
    release_n = 1'b0;
    hold_cnt_n = held && hold_cnt != LONG_MAX ? hold_cnt + 24'd1 : hold_cnt;
    case (state)
      RELEASED: state_n = s ? RELEASED : PRESS_WAIT;
      PRESS_WAIT:
        if (s) state_n = RELEASED;
        else if (accept) begin
          state_n = PRESSED;
          btn_n = 1'b0;
          press_n = 1'b1;
          hold_cnt_n = '0;
        end else db_cnt_n = db_cnt + 24'd1;
      PRESSED: state_n = s ? RELEASE_WAIT : PRESSED;
      RELEASE_WAIT:
        if (!s) state_n = PRESSED;
        else if (accept) begin
          state_n = RELEASED;
          btn_n = 1'b1;
          release_n = 1'b1;
        end else db_cnt_n = db_cnt + 24'd1;
      default: state_n = RELEASED;
    endcase
    long_n = held && !release_n && hold_cnt == LONG_MAX - 24'd1;
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed stimulus checked against a run-length model of the debouncer
module tb_btn_debounce;
  localparam int DB = 4;
  localparam int LONG = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnIn = 1'b1;
  logic btnOut, pressPulse, releasePulse, longPress;
  int tests = 0, fails = 0, cyc = 0, e = 0;
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b1, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
  int m_run = 0, m_since = 0;
  int press_cyc = -1, rel_cyc = -1, long_cyc = -1, n_press = 0, n_rel = 0, n_long = 0;
  btn_debounce #(.DB_CNT(DB), .LONG_CNT(LONG)) dut (
    .clk(clk),
    .rst(rst),
    .btnIn(btnIn),
    .btnOut(btnOut),
    .pressPulse(pressPulse),
    .releasePulse(releasePulse),
    .longPress(longPress)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = 1'b1;
    m_s2 = 1'b1;
    m_lvl = 1'b1;
    m_run = 0;
    m_since = 0;
    m_press = 1'b0;
    m_rel = 1'b0;
    m_long = 1'b0;
  endtask
  task automatic model_edge();
    logic s;
    m_press = 1'b0;
    m_rel = 1'b0;
    m_long = 1'b0;
    if (rst) model_reset();
    else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = btnIn;
      m_run = (s != m_lvl) ? m_run + 1 : 0;
      if (!m_lvl) begin
        m_since++;
        if (m_run == DB + 1) begin
          m_lvl = 1'b1;
          m_rel = 1'b1;
          m_run = 0;
        end else m_long = (m_since == LONG);
      end else if (m_run == DB + 1) begin
        m_lvl = 1'b0;
        m_press = 1'b1;
        m_run = 0;
        m_since = 0;
      end
    end
  endtask
  task automatic tick(input logic b);
    btnIn = b;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check("btnOut", 32'(btnOut), 32'(m_lvl));
    check("pressPulse", 32'(pressPulse), 32'(m_press));
    check("releasePulse", 32'(releasePulse), 32'(m_rel));
    check("longPress", 32'(longPress), 32'(m_long));
    if (pressPulse) begin press_cyc = cyc; n_press++; end
    if (releasePulse) begin rel_cyc = cyc; n_rel++; end
    if (longPress) begin long_cyc = cyc; n_long++; end
  endtask
  task automatic areset();
    #1 rst = 1'b1;
    #1;
    check("async btnOut", 32'(btnOut), 1);
    check("async pulses", 32'({pressPulse, releasePulse, longPress}), 0);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 8; i++) tick(i[0]);
    rst = 1'b0;
    repeat (6) tick(1'b1);
    check("no pulses after reset", n_press + n_rel + n_long, 0);
    tick(1'b0);
    e = cyc;
    repeat (10) tick(1'b0);
    check("press latency", press_cyc - e, 6);
    check("press count", n_press, 1);
    tick(1'b1);
    e = cyc;
    repeat (10) tick(1'b1);
    check("release latency", rel_cyc - e, 6);
    check("no long on short press", n_long, 0);
    for (int k = 0; k < 5; k++) begin
      repeat (3) tick(1'b0);
      repeat (2) tick(1'b1);
    end
    check("bounce press count", n_press, 1);
    check("bounce btnOut", 32'(btnOut), 1);
    tick(1'b0);
    e = cyc;
    repeat (130) tick(1'b0);
    check("hold after bounce latency", press_cyc - e, 6);
    check("long delay", long_cyc - press_cyc, 20);
    check("long once", n_long, 1);
    repeat (10) tick(1'b1);
    repeat (10) tick(1'b0);
    repeat (2) tick(1'b1);
    repeat (30) tick(1'b0);
    check("glitch no release", n_rel, 2);
    check("glitch btnOut", 32'(btnOut), 0);
    check("glitch long delay", long_cyc - press_cyc, 20);
    check("glitch long count", n_long, 2);
    repeat (10) tick(1'b1);
    repeat (3) tick(1'b0);
    areset();
    check("press wait abort", n_press, 3);
    tick(1'b0);
    e = cyc;
    repeat (10) tick(1'b0);
    check("post reset latency", press_cyc - e, 6);
    check("post reset press count", n_press, 4);
    areset();
    check("pressed abort no release", n_rel, 3);
    tick(1'b0);
    e = cyc;
    repeat (10) tick(1'b0);
    check("second post reset latency", press_cyc - e, 6);
    check("final release count", n_rel, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DB_CNT, default 50000, the number of consecutive stable clocks required to accept a level change; legal range 2..2^24-1.
REQ-002 SHALL have parameter LONG_CNT, default 2000000, the number of clocks after press acceptance at which long-press is flagged; legal range DB_CNT+1..2^24-1.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high; driven from the board power-on reset and never from the downstream pushbutton reset output.
REQ-005 SHALL have port btnIn, input, 1 bit: raw mechanical pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port btnOut, output, 1 bit: debounced button level, active-low; drives the rstIn input of the downstream pushbutton-reset synchronizer.
REQ-007 SHALL have port pressPulse, output, 1 bit: one-clock pulse when a press is accepted.
REQ-008 SHALL have port releasePulse, output, 1 bit: one-clock pulse when a release is accepted.
REQ-009 SHALL have port longPress, output, 1 bit: one-clock pulse, at most once per accepted press.

Function
REQ-010 SHALL pass btnIn through a 2-flop synchronizer; the synchronized value is s, and no logic other than the first flop samples btnIn.
REQ-011 SHALL implement FSM states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 In RELEASED with s=0, the FSM SHALL go to PRESS_WAIT with db_cnt=0.
REQ-013 In PRESS_WAIT with s=1, the FSM SHALL return to RELEASED with db_cnt=0 and no output change.
REQ-014 In PRESS_WAIT with s=0, db_cnt SHALL increment; on the edge where db_cnt==DB_CNT-1 and s=0, the FSM SHALL enter PRESSED, drive btnOut=0, pulse pressPulse=1 and clear hold_cnt.
REQ-015 PRESSED and RELEASE_WAIT SHALL behave as the mirror of REQ-012..014 (s=1 starts the release); acceptance SHALL drive btnOut=1 and pulse releasePulse=1.
REQ-016 Latency: when btnIn changes and stays stable, btnOut and the matching pulse SHALL update exactly DB_CNT+2 clocks after the first edge that samples the new level.
REQ-017 hold_cnt SHALL be 24 bits, increment every clock in PRESSED and RELEASE_WAIT, and saturate at LONG_CNT.
REQ-018 longPress SHALL pulse for one clock exactly LONG_CNT clocks after the pressPulse edge, provided no release has been accepted; it SHALL NOT repeat within the same press.
REQ-019 A bounce that reverts RELEASE_WAIT to PRESSED SHALL NOT clear or pause hold_cnt.
REQ-020 pressPulse, releasePulse and longPress SHALL be registered and never high simultaneously except longPress with no other pulse; glitch-free.
REQ-021 db_cnt SHALL be 24 bits and SHALL never wrap; it clears on every state change.

Reset
REQ-022 While rst=1, the block SHALL immediately force state=RELEASED, both synchronizer flops=1, db_cnt=0, hold_cnt=0, btnOut=1, pressPulse=0, releasePulse=0 and longPress=0.
REQ-023 Reset asserted mid-operation (any state) SHALL abort it with no pulse emitted.
REQ-024 After rst deasserts with btnIn held low, a press SHALL be accepted after the full REQ-016 latency.

Verification (DB_CNT=4, LONG_CNT=20)
REQ-025 Reset: rst=1 with btnIn toggling -> btnOut=1 and all pulses 0 throughout; release rst -> outputs unchanged while btnIn=1.
REQ-026 Clean press: btnIn 1->0 sampled at edge E0 and held -> btnOut=0 and pressPulse=1 at E0+6 only; release sampled at E1 -> btnOut=1 and releasePulse=1 at E1+6.
REQ-027 Bounce: btnIn low for 3 clocks then high, repeated 5 times -> btnOut stays 1 with no pulses; then held low -> press accepted 6 clocks after the last falling sample.
REQ-028 Long press: held low -> longPress pulses once, 20 clocks after pressPulse; held 100 more clocks -> no further longPress.
REQ-029 Release glitch: in PRESSED, btnIn high for 2 clocks -> btnOut stays 0 with no releasePulse, and longPress timing is unchanged.
REQ-030 Async reset: rst pulsed between clock edges while in PRESS_WAIT, and again in PRESSED -> btnOut=1 before the next edge, no pulses, and REQ-024 holds afterwards.
